// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one CPU load/store at a time with a fixed response latency.
// Define DMEM_BYTE_WRITE_EN to honour req_be on stores; otherwise every store writes the full word.
module data_mem_responder #(
  parameter int W       = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = (W / 8 < 4) ? W / 8 : 4;
  localparam logic [W:0] ADDR_LIMIT = (W+1)'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [W-1:0] mem [DEPTH];
  logic         accept;
  logic         req_err;
  logic [AW-1:0] word_idx;
  logic [W-1:0] wr_mask;

  assign accept   = (state == IDLE) && req_valid;
  assign req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign word_idx = req_addr[AW+1:2];

`ifdef DMEM_BYTE_WRITE_EN
  always_comb begin
    wr_mask = '1;
    for (int b = 0; b < NB; b++) wr_mask[8*b +: 8] = {8{req_be[b]}};
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign wr_mask   = '1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else cnt_nxt = cnt - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory and response register are both updated only at the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_err   <= req_err;
        rsp_rdata <= (!req_err && !req_we) ? mem[word_idx] : '0;
        if (!req_err && req_we)
          mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (req_wdata & wr_mask);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three instances (LATENCY 2, 1, 4) against a word-array model.
module tb_data_mem_responder;
  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int ND    = 3;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid [ND];
  logic         req_ready [ND];
  logic         req_we    [ND];
  logic [W-1:0] req_addr  [ND];
  logic [W-1:0] req_wdata [ND];
  logic [3:0]   req_be    [ND];
  logic         rsp_valid [ND];
  logic         rsp_ready [ND];
  logic [W-1:0] rsp_rdata [ND];
  logic         rsp_err   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_responder #(.W(W), .DEPTH(DEPTH), .LATENCY(lat_of(g))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference memory: one word array per instance.
  logic [W-1:0] mdl [ND][DEPTH];

  task automatic model_clear();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wd,
                                         input logic [3:0] be);
    logic [W-1:0] r;
`ifdef DMEM_BYTE_WRITE_EN
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
`else
    r = wd;
`endif
    return r;
  endfunction

  // Called at a falling edge with the instance idle; returns at a falling edge.
  task automatic xact(input int d, input logic we, input logic [W-1:0] addr,
                      input logic [W-1:0] wdata, input logic [3:0] be, input int hold,
                      output logic [W-1:0] rd_o, output logic err_o);
    logic         err_e;
    logic [W-1:0] exp_rd;
    int           n;
    int           idx;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_before_req", W'(req_ready[d]), 1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    rsp_ready[d] = 1'($urandom_range(0, 1));
    err_e  = (addr[1:0] != 2'b00) || (addr >= DEPTH * 4);
    exp_rd = '0;
    if (!err_e) begin
      idx = int'(addr >> 2);
      if (we) mdl[d][idx] = merge(mdl[d][idx], wdata, be);
      else exp_rd = mdl[d][idx];
    end
    @(posedge clk);
    n = 0;
    // After accept the bundle is garbage and must be ignored until the next idle cycle.
    while (1) begin
      @(negedge clk);
      n++;
      req_valid[d] = 1'($urandom_range(0, 1));
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = 32'($urandom_range(0, 63)) << 2;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);
      if (rsp_valid[d] || n >= 20) break;
      rsp_ready[d] = 1'($urandom_range(0, 1));
    end
    rsp_ready[d] = 1'b0;
    check_eq("latency", n, lat_of(d));
    check_eq("rsp_valid", W'(rsp_valid[d]), 1);
    check_eq("rsp_rdata", rsp_rdata[d], exp_rd);
    check_eq("rsp_err", W'(rsp_err[d]), W'(err_e));
    check_eq("req_ready_in_resp", W'(req_ready[d]), 0);
    rd_o  = rsp_rdata[d];
    err_o = rsp_err[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", W'(rsp_valid[d]), 1);
      check_eq("hold_rsp_rdata", rsp_rdata[d], rd_o);
      check_eq("hold_req_ready", W'(req_ready[d]), 0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    check_eq("post_hs_rsp_valid", W'(rsp_valid[d]), 0);
    check_eq("post_hs_req_ready", W'(req_ready[d]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rd;
    logic         er;
    logic [W-1:0] a;
    int           kind;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b0;
    end
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_eq("reset_rsp_valid", W'(rsp_valid[d]), 0);
      check_eq("reset_rsp_rdata", rsp_rdata[d], 0);
      check_eq("reset_rsp_err", W'(rsp_err[d]), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_eq("req_ready_after_reset", W'(req_ready[d]), 1);

    // Store then load round trip.
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check_eq("load_deadbeef", rd, 32'hDEADBEEF);
    check_eq("load_deadbeef_err", W'(er), 0);

    // Byte-enable merge.
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
    xact(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 1, rd, er);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_BYTE_WRITE_EN
    check_eq("byte_merge", rd, 32'h112233AA);
`else
    check_eq("byte_merge", rd, 32'h000000AA);
`endif

    // Misaligned and out-of-range requests.
    xact(0, 1'b1, DEPTH * 4 - 4, 32'hCAFEF00D, 4'hF, 0, rd, er);
    xact(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er);
    check_eq("misaligned_err", W'(er), 1);
    check_eq("misaligned_rdata", rd, 0);
    xact(0, 1'b1, DEPTH * 4, 32'h12345678, 4'hF, 0, rd, er);
    check_eq("oor_err", W'(er), 1);
    check_eq("oor_rdata", rd, 0);
    xact(0, 1'b0, DEPTH * 4 - 4, 32'h0, 4'h0, 0, rd, er);
    check_eq("last_word_intact", rd, 32'hCAFEF00D);

    // Response backpressure.
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    check_eq("backpressure_rdata", rd, 32'hDEADBEEF);

    // Random traffic on every latency variant.
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 50; k++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0)
          a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
        else if (kind == 1)
          a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
        else if (kind == 2)
          a = 32'(DEPTH * 4 - 4);
        else
          a = 32'($urandom_range(0, 7)) * 4;
        xact(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
             $urandom_range(0, 3), rd, er);
      end
    end

    // Reset while a load is waiting.
    xact(2, 1'b1, 32'h4, 32'h55, 4'hF, 0, rd, er);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_wait_rsp_valid", W'(rsp_valid[2]), 0);
    check_eq("rst_wait_rsp_rdata", rsp_rdata[2], 0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_wait_req_ready", W'(req_ready[2]), 1);
    xact(2, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er);
    check_eq("rst_wait_mem_cleared", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter W, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 256, number of W-bit words stored.
REQ-003 Parameter LATENCY, default 2, clock edges from request accept to rsp_valid assertion; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 req_valid  in  1  CPU load/store request present.
REQ-007 req_ready  out  1  responder can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  W  byte address.
REQ-010 req_wdata  in  W  store data.
REQ-011 req_be  in  4  byte enables for stores; bit i selects wdata[8i+7:8i].
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  CPU accepts the response.
REQ-014 rsp_rdata  out  W  load data; 0 for stores and errors.
REQ-015 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-016 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted on a rising edge with req_valid=1 in IDLE; the bundle SHALL be sampled only then.
REQ-018 The error condition is req_addr[1:0]!=0 or req_addr>=DEPTH*4; word index = req_addr[log2(DEPTH)+1:2].
REQ-019 On an accepted error-free store, enabled bytes SHALL be written at the accept edge; disabled bytes keep their value.
REQ-020 On an accepted error-free load, the word SHALL be captured into the response register at the accept edge.
REQ-021 A load accepted after a store SHALL return the stored data.
REQ-022 An errored request SHALL not modify memory; its response SHALL have rsp_err=1 and rsp_rdata=0.
REQ-023 With LATENCY=1, the FSM SHALL go IDLE->RESP at the accept edge.
REQ-024 With LATENCY>1, the FSM SHALL go IDLE->WAIT, load a counter with LATENCY-2, decrement each edge, and go to RESP on the edge where the counter is 0.
REQ-025 In RESP, rsp_valid SHALL be 1; rsp_rdata and rsp_err SHALL stay stable until the edge with rsp_ready=1.
REQ-026 On that edge the FSM SHALL return to IDLE; back-to-back accept is not allowed, so one idle cycle with req_ready=1 precedes the next accept.
REQ-027 req_valid in WAIT or RESP SHALL be ignored; the CPU holds the request until req_ready=1.
REQ-028 rsp_ready outside RESP SHALL have no effect.

Reset
REQ-029 rst=0 SHALL force IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, and clear all memory words to 0, asynchronously and regardless of state.
REQ-030 Reset in WAIT or RESP SHALL drop the pending response; a store already written at its accept edge is then cleared by the memory clear.
REQ-031 After rst returns to 1, req_ready SHALL be 1 on the first cycle.

Configuration
REQ-032 Macro DMEM_BYTE_WRITE_EN.
- Defined: req_be is honoured per REQ-019.
- Undefined: req_be is ignored and every error-free store writes the full word.

Verification
REQ-033 Reset, then store 0xDEADBEEF at 0x10 with be=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF with rsp_valid exactly LATENCY edges after each accept, rsp_err=0.
REQ-034 Byte merge:
- 0x11223344 stored at 0x20, then 0x000000AA stored with be=4'b0001, then load 0x20.
- With DMEM_BYTE_WRITE_EN: 0x112233AA.
- Without it: 0x000000AA.
REQ-035 Load 0x22 (misaligned) and store to DEPTH*4 (out of range) -> rsp_err=1, rsp_rdata=0; a later load of DEPTH*4-4 returns its prior value.
REQ-036 Response backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_rdata stable, req_ready=0; FSM returns to IDLE on the edge with rsp_ready=1.
REQ-037 Reset mid-WAIT:
- Store 0x55 at 0x4, then load 0x4 and assert rst=0 one cycle after the load accept.
- Required: rsp_valid=0 immediately and req_ready=1 after release.
- A subsequent load of 0x4 returns 0.
REQ-038 Sweep LATENCY=1 and LATENCY=4: accept-to-rsp_valid distance measured as 1 and 4 edges.
